// File: rtl/wheel_kinematics_pkg.sv
// Shared constants, state encoding and saturation helper for the mecanum
// inverse-kinematics datapath.
package wheel_kinematics_pkg;

  localparam int DATAWIDTH_N  = 32;
  localparam int FRACTIONAL_Q = 15;

  localparam logic signed [31:0] SAT_MAX    = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN    = 32'sh8000_0000;
  localparam logic signed [31:0] INV_RADIUS = 32'sd819200;
  localparam logic signed [31:0] LXLY       = 32'sd6554;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL_K  = 3'd1,
    ST_SUM    = 3'd2,
    ST_MUL_W1 = 3'd3,
    ST_MUL_W2 = 3'd4,
    ST_MUL_W3 = 3'd5,
    ST_MUL_W4 = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // Clamp a wide signed intermediate (33-bit sums are sign-extended by the
  // caller, 64-bit products come in directly) into the 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      return SAT_MAX;
    end else if (v < -64'sh0000_0000_8000_0000) begin
      return SAT_MIN;
    end else begin
      return $signed(v[31:0]);
    end
  endfunction

endpackage

// File: rtl/fixed_mul_sat.sv
// Combinational signed fixed-point multiply: full 64-bit product, arithmetic
// shift by the fractional width (floors toward -inf), then saturate.
module fixed_mul_sat
  import wheel_kinematics_pkg::*;
#(
  parameter int FRAC = FRACTIONAL_Q
) (
  input  logic signed [31:0] op_a,
  input  logic signed [31:0] op_b,
  output logic signed [31:0] prod_sat
);

  logic signed [63:0] prod_full;
  logic signed [63:0] prod_shr;

  // Product, rescale and clamp.
  always_comb begin
    prod_full = 64'(op_a) * 64'(op_b);
    prod_shr  = prod_full >>> FRAC;
    prod_sat  = sat32(prod_shr);
  end

endmodule

// File: rtl/wheel_setpoint_calculator.sv
// Mecanum inverse kinematics: body velocity (vx, vy, wz) to four wheel
// setpoints, stepping one shared saturating multiplier through an FSM.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for START; inputs latched on START
// MUL_K     | k <- sat(LXLY * wz)
// SUM       | s1..s4 <- sat(a-k), sat(b+k), sat(b-k), sat(a+k)
// MUL_W1..4 | t_n <- sat(s_n * INV_RADIUS)
// DONE      | W1..W4 <- t1..t4 together, DONE pulse next cycle
module wheel_setpoint_calculator
  import wheel_kinematics_pkg::*;
(
  input  logic                   WHEEL_SETPOINT_CLOCK_50,
  input  logic                   WHEEL_SETPOINT_Reset_InLow,
  input  logic                   WHEEL_SETPOINT_START_In,
  input  logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_VX_InBus,
  input  logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_VY_InBus,
  input  logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_WZ_InBus,
  output logic                   WHEEL_SETPOINT_BUSY_Out,
  output logic                   WHEEL_SETPOINT_DONE_Out,
  output logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_W1_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_W2_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_W3_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_SETPOINT_W4_OutBus
);

  state_t state_q, state_d;
  logic signed [31:0] vx_q, vx_d, vy_q, vy_d, wz_q, wz_d, k_q, k_d;
  logic signed [31:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic signed [31:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, t4_q, t4_d;
  logic signed [31:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d, w4_q, w4_d;
  logic               done_q, done_d;

  logic signed [31:0] mul_a, mul_b, mul_y;
  logic signed [31:0] a_sat, b_sat;

  fixed_mul_sat u_mul (
    .op_a     (mul_a),
    .op_b     (mul_b),
    .prod_sat (mul_y)
  );

  // Operand mux for the shared multiplier, kept apart from the next-state
  // logic so the product does not feed back into its own selecting block.
  always_comb begin
    mul_a = LXLY;
    mul_b = wz_q;
    case (state_q)
      ST_MUL_W1: begin mul_a = s1_q; mul_b = INV_RADIUS; end
      ST_MUL_W2: begin mul_a = s2_q; mul_b = INV_RADIUS; end
      ST_MUL_W3: begin mul_a = s3_q; mul_b = INV_RADIUS; end
      ST_MUL_W4: begin mul_a = s4_q; mul_b = INV_RADIUS; end
      default:   begin mul_a = LXLY; mul_b = wz_q;       end
    endcase
  end

  // a and b are clamped on their own before k is folded in.
  always_comb begin
    a_sat = sat32(64'(33'(vx_q) - 33'(vy_q)));
    b_sat = sat32(64'(33'(vx_q) + 33'(vy_q)));
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    vx_d = vx_q; vy_d = vy_q; wz_d = wz_q; k_d = k_q;
    s1_d = s1_q; s2_d = s2_q; s3_d = s3_q; s4_d = s4_q;
    t1_d = t1_q; t2_d = t2_q; t3_d = t3_q; t4_d = t4_q;
    w1_d = w1_q; w2_d = w2_q; w3_d = w3_q; w4_d = w4_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (WHEEL_SETPOINT_START_In) begin
          vx_d    = $signed(WHEEL_SETPOINT_VX_InBus);
          vy_d    = $signed(WHEEL_SETPOINT_VY_InBus);
          wz_d    = $signed(WHEEL_SETPOINT_WZ_InBus);
          state_d = ST_MUL_K;
        end
      end
      ST_MUL_K: begin
        k_d     = mul_y;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        s1_d    = sat32(64'(33'(a_sat) - 33'(k_q)));
        s2_d    = sat32(64'(33'(b_sat) + 33'(k_q)));
        s3_d    = sat32(64'(33'(b_sat) - 33'(k_q)));
        s4_d    = sat32(64'(33'(a_sat) + 33'(k_q)));
        state_d = ST_MUL_W1;
      end
      ST_MUL_W1: begin t1_d = mul_y; state_d = ST_MUL_W2; end
      ST_MUL_W2: begin t2_d = mul_y; state_d = ST_MUL_W3; end
      ST_MUL_W3: begin t3_d = mul_y; state_d = ST_MUL_W4; end
      ST_MUL_W4: begin t4_d = mul_y; state_d = ST_DONE;   end
      ST_DONE: begin
        w1_d = t1_q; w2_d = t2_q; w3_d = t3_q; w4_d = t4_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any run.
  always_ff @(posedge WHEEL_SETPOINT_CLOCK_50 or negedge WHEEL_SETPOINT_Reset_InLow) begin
    if (!WHEEL_SETPOINT_Reset_InLow) begin
      state_q <= ST_IDLE;
      vx_q <= '0; vy_q <= '0; wz_q <= '0; k_q <= '0;
      s1_q <= '0; s2_q <= '0; s3_q <= '0; s4_q <= '0;
      t1_q <= '0; t2_q <= '0; t3_q <= '0; t4_q <= '0;
      w1_q <= '0; w2_q <= '0; w3_q <= '0; w4_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vx_q <= vx_d; vy_q <= vy_d; wz_q <= wz_d; k_q <= k_d;
      s1_q <= s1_d; s2_q <= s2_d; s3_q <= s3_d; s4_q <= s4_d;
      t1_q <= t1_d; t2_q <= t2_d; t3_q <= t3_d; t4_q <= t4_d;
      w1_q <= w1_d; w2_q <= w2_d; w3_q <= w3_d; w4_q <= w4_d;
      done_q <= done_d;
    end
  end

  assign WHEEL_SETPOINT_BUSY_Out  = (state_q != ST_IDLE);
  assign WHEEL_SETPOINT_DONE_Out  = done_q;
  assign WHEEL_SETPOINT_W1_OutBus = w1_q;
  assign WHEEL_SETPOINT_W2_OutBus = w2_q;
  assign WHEEL_SETPOINT_W3_OutBus = w3_q;
  assign WHEEL_SETPOINT_W4_OutBus = w4_q;

endmodule

// File: tb/tb_wheel_setpoint_calculator.sv
// Bench for wheel_setpoint_calculator: a cycle-level reference model built
// from the kinematic equations, compared every cycle, plus literal pins.
module tb_wheel_setpoint_calculator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] vx, vy, wz;
  logic        busy, done;
  logic [31:0] w1, w2, w3, w4;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  always #10 clk = ~clk;

  wheel_setpoint_calculator dut (
    .WHEEL_SETPOINT_CLOCK_50    (clk),
    .WHEEL_SETPOINT_Reset_InLow (rst_n),
    .WHEEL_SETPOINT_START_In    (start),
    .WHEEL_SETPOINT_VX_InBus    (vx),
    .WHEEL_SETPOINT_VY_InBus    (vy),
    .WHEEL_SETPOINT_WZ_InBus    (wz),
    .WHEEL_SETPOINT_BUSY_Out    (busy),
    .WHEEL_SETPOINT_DONE_Out    (done),
    .WHEEL_SETPOINT_W1_OutBus   (w1),
    .WHEEL_SETPOINT_W2_OutBus   (w2),
    .WHEEL_SETPOINT_W3_OutBus   (w3),
    .WHEEL_SETPOINT_W4_OutBus   (w4)
  );

  // ---------------- reference model ----------------
  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat((a * b) >>> 15);
  endfunction

  function automatic logic [127:0] ik(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    longint lx, ly, lz, k, a, b, r1, r2, r3, r4;
    lx = longint'($signed(x));
    ly = longint'($signed(y));
    lz = longint'($signed(z));
    k  = fmul(64'sd6554, lz);
    a  = sat(lx - ly);
    b  = sat(lx + ly);
    r1 = fmul(sat(a - k), 64'sd819200);
    r2 = fmul(sat(b + k), 64'sd819200);
    r3 = fmul(sat(b - k), 64'sd819200);
    r4 = fmul(sat(a + k), 64'sd819200);
    return {r1[31:0], r2[31:0], r3[31:0], r4[31:0]};
  endfunction

  // Model timing: a request accepted when idle completes 8 edges later.
  int           phase;
  logic [127:0] pend;
  logic [127:0] exp_w;
  logic         exp_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 0;
      pend     <= '0;
      exp_w    <= '0;
      exp_done <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (phase == 0) begin
        if (start) begin
          phase <= 1;
          pend  <= ik(vx, vy, wz);
        end
      end else if (phase == 7) begin
        phase    <= 0;
        exp_w    <= pend;
        exp_done <= 1'b1;
      end else begin
        phase <= phase + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (phase != 0)});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("w1", w1, exp_w[127:96]);
      chk("w2", w2, exp_w[95:64]);
      chk("w3", w3, exp_w[63:32]);
      chk("w4", w4, exp_w[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  // Issue one request from idle, scramble inputs while busy, wait for DONE.
  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                     output int busy_cyc);
    logic got;
    busy_cyc = 0;
    got = 1'b0;
    @(negedge clk);
    vx = x; vy = y; wz = z; start = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      vx = $urandom; vy = $urandom; wz = $urandom;
      if (done) got = 1'b1;
      else if (busy) busy_cyc++;
    end
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no DONE within 20 cycles, expected one");
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 65535) - 32768;
      1:       return $urandom_range(0, 2000000) - 1000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc, dcnt;
    rst_n = 1'b0; start = 1'b0; vx = '0; vy = '0; wz = '0;
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_w1", w1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pure forward motion.
    run(32'd32768, 32'd0, 32'd0, bc);
    chk("t1_busy_cycles", bc, 32'd7);
    chk("t1_w1", w1, 32'd819200);
    chk("t1_w4", w4, 32'd819200);

    // Pure strafe.
    run(32'd0, 32'd32768, 32'd0, bc);
    chk("t2_w1", w1, -32'sd819200);
    chk("t2_w2", w2, 32'd819200);
    chk("t2_w4", w4, -32'sd819200);

    // Pure rotation.
    run(32'd0, 32'd0, 32'd32768, bc);
    chk("t3_w1", w1, -32'sd163850);
    chk("t3_w2", w2, 32'd163850);
    chk("t3_w3", w3, -32'sd163850);

    // Saturation in b and in the multiply.
    run(32'h7FFF_0000, 32'h7FFF_0000, 32'd0, bc);
    chk("t4_w1", w1, 32'd0);
    chk("t4_w2", w2, 32'h7FFF_FFFF);
    chk("t4_w3", w3, 32'h7FFF_FFFF);
    run(32'h8001_0000, 32'h8001_0000, 32'd0, bc);
    chk("t4n_w2", w2, 32'h8000_0000);
    chk("t4n_w4", w4, 32'd0);

    // START held high: one DONE every 8 cycles.
    @(negedge clk);
    vx = 32'd1000; vy = 32'd2000; wz = 32'd3000; start = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      vx = rnd_val(); vy = rnd_val(); wz = rnd_val();
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("t5_held_dones", dcnt, 32'd5);

    // START pulses during MUL_W2 and DONE are ignored.
    @(negedge clk);
    vx = 32'd5000; vy = -32'sd7000; wz = 32'd11000; start = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 3) || (i == 6);
      vx = rnd_val(); vy = rnd_val(); wz = rnd_val();
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("t5_pulse_dones", dcnt, 32'd1);

    // Reset during MUL_W3 aborts the run.
    @(negedge clk);
    vx = 32'd40000; vy = 32'd1234; wz = 32'd999; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_w2", w2, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'd32768, 32'd0, 32'd0, bc);
    chk("t6_busy_cycles", bc, 32'd7);
    chk("t6_w3", w3, 32'd819200);

    // Randomized requests against the model.
    for (int n = 0; n < 30; n++) begin
      run(rnd_val(), rnd_val(), rnd_val(), bc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
